// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE/ACCESS/WAIT/DONE sequencer with a fixed memory latency.
// Define ARB_RR_EN for round-robin between the two ports; port 0 has fixed priority otherwise.
module mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req0,
  input  logic        wr0,
  input  logic [11:0] addr0,
  input  logic [15:0] wdata0,
  output logic        ack0,
  input  logic        req1,
  input  logic        wr1,
  input  logic [11:0] addr1,
  input  logic [15:0] wdata1,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [11:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_dout,
  input  logic [15:0] mem_din
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       win;
  logic       lat_wr;
  logic       pick1;

`ifdef ARB_RR_EN
  // last == 1 means port 1 was served most recently
  logic last;

  assign pick1 = req1 && (!req0 || !last);

  always_ff @(posedge clk) begin
    if (!clr) begin
      last <= 1'b1;
    end else if (state == S_DONE) begin
      last <= win;
    end
  end
`else
  assign pick1 = req1 && !req0;
`endif

  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      win      <= 1'b0;
      lat_wr   <= 1'b0;
      mem_addr <= 12'd0;
      mem_dout <= 16'd0;
      rdata    <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            win      <= pick1;
            lat_wr   <= pick1 ? wr1 : wr0;
            mem_addr <= pick1 ? addr1 : addr0;
            mem_dout <= pick1 ? wdata1 : wdata0;
            state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          cnt   <= 4'd0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == LAST) begin
            state <= S_DONE;
            if (!lat_wr) begin
              rdata <= mem_din;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state != S_IDLE);
  assign mem_rd = (state == S_ACCESS) && !lat_wr;
  assign mem_wr = (state == S_ACCESS) && lat_wr;
  assign ack0   = (state == S_DONE) && !win;
  assign ack1   = (state == S_DONE) && win;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected accesses queued at request time,
// checked against memory strobes and acks as they appear.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [11:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, busy, mem_rd, mem_wr;
  logic [15:0] rdata, mem_dout, mem_din;
  logic [11:0] mem_addr;
  logic [15:0] din_val = '0;

  assign mem_din = din_val;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din)
  );

  typedef struct {
    logic        port;
    logic        wr;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [15:0] model_rdata = '0;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (clr) begin
      if (mem_rd || mem_wr) begin
        checks++;
        if (mem_rd) rd_cnt++;
        if (mem_wr) wr_cnt++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL strobe: unexpected access addr=%h", mem_addr);
        end else if ((mem_rd && mem_wr) || mem_wr !== sb[0].wr ||
                     mem_addr !== sb[0].addr ||
                     (sb[0].wr && mem_dout !== sb[0].wdata)) begin
          failures++;
          $display("FAIL strobe: got rd=%b wr=%b addr=%h dout=%h want wr=%b addr=%h dout=%h",
                   mem_rd, mem_wr, mem_addr, mem_dout,
                   sb[0].wr, sb[0].addr, sb[0].wdata);
        end
      end
      if (ack0 || ack1) begin
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL ack: unexpected ack0=%b ack1=%b", ack0, ack1);
        end else begin
          e = sb.pop_front();
          if ((ack0 && ack1) || ack1 !== e.port || rdata !== e.rd) begin
            failures++;
            $display("FAIL ack: got ack0=%b ack1=%b rdata=%h want port=%0d rdata=%h",
                     ack0, ack1, rdata, e.port, e.rd);
          end
        end
      end
    end
  end

  task automatic push(input logic p, input logic w, input logic [11:0] a,
                      input logic [15:0] d);
    exp_t e;
    if (!w) model_rdata = din_val;
    e.port = p; e.wr = w; e.addr = a; e.wdata = d; e.rd = model_rdata;
    sb.push_back(e);
  endtask

  task automatic wait_ack(output int n, output logic p);
    bit found = 0;
    n = -1;
    p = 1'bx;
    for (int i = 1; i <= 50 && !found; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        n = i;
        p = ack1;
        found = 1;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack0, ack1} !== 2'b00) begin
      failures++; $display("FAIL reset_ack: got %b want 00", {ack0, ack1});
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if ({mem_rd, mem_wr} !== 2'b00) begin
      failures++; $display("FAIL reset_strobe: got %b want 00", {mem_rd, mem_wr});
    end
    checks++;
    if ({mem_addr, mem_dout, rdata} !== 44'd0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h dout=%h rdata=%h want 0",
               mem_addr, mem_dout, rdata);
    end
    req0 = 1'b0; req1 = 1'b0; clr = 1'b1;
    model_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_read();
    int n; logic p; int r0;
    r0 = rd_cnt;
    din_val = 16'hBEEF;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h123; wdata0 = 16'h0000;
    push(1'b0, 1'b0, 12'h123, 16'h0000);
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 12'h123 || busy !== 1'b1) begin
      failures++;
      $display("FAIL read_access: got rd=%b addr=%h busy=%b want 1/123/1",
               mem_rd, mem_addr, busy);
    end
    addr0 = 12'h000; wr0 = 1'b1; wdata0 = 16'hDEAD;
    wait_ack(n, p);
    req0 = 1'b0; wr0 = 1'b0;
    checks++;
    if (n !== LAT + 1 || p !== 1'b0) begin
      failures++;
      $display("FAIL read_latency: got n=%0d port=%b want n=%0d port=0", n + 1, p, LAT + 2);
    end
    checks++;
    if (rdata !== 16'hBEEF || rd_cnt - r0 !== 1) begin
      failures++;
      $display("FAIL read_data: got rdata=%h strobes=%0d want BEEF/1", rdata, rd_cnt - r0);
    end
    @(negedge clk);
  endtask

  task automatic test_write();
    int n; logic p; int w0;
    w0 = wr_cnt;
    din_val = 16'h0F0F;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 12'hFFF; wdata1 = 16'h1234;
    push(1'b1, 1'b1, 12'hFFF, 16'h1234);
    wait_ack(n, p);
    req1 = 1'b0; wr1 = 1'b0;
    checks++;
    if (n !== LAT + 2 || p !== 1'b1) begin
      failures++;
      $display("FAIL write_ack: got n=%0d port=%b want n=%0d port=1", n, p, LAT + 2);
    end
    checks++;
    if (rdata !== 16'hBEEF || wr_cnt - w0 !== 1) begin
      failures++;
      $display("FAIL write_rdata: got rdata=%h strobes=%0d want BEEF/1", rdata, wr_cnt - w0);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int n; logic p;
    logic order [4];
`ifdef ARB_RR_EN
    order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    order = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    din_val = 16'h1357;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h0AA;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 12'h0BB; wdata1 = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      if (order[i]) push(1'b1, 1'b1, 12'h0BB, 16'h5555);
      else push(1'b0, 1'b0, 12'h0AA, 16'h0000);
    end
    for (int i = 0; i < 4; i++) begin
      wait_ack(n, p);
      checks++;
      if (p !== order[i] || n !== ((i == 0) ? LAT + 2 : LAT + 3)) begin
        failures++;
        $display("FAIL contention_%0d: got port=%b n=%0d want port=%b n=%0d",
                 i, p, n, order[i], (i == 0) ? LAT + 2 : LAT + 3);
      end
    end
    req0 = 1'b0; req1 = 1'b0; wr1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int n; logic p;
    din_val = 16'h7777;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h055;
    push(1'b0, 1'b0, 12'h055, 16'h0000);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack0, ack1, mem_rd, mem_wr, busy} !== 5'b0 || rdata !== 16'h0) begin
      failures++;
      $display("FAIL abort_state: got ack=%b%b strobe=%b%b busy=%b rdata=%h want all 0",
               ack0, ack1, mem_rd, mem_wr, busy, rdata);
    end
    req0 = 1'b0; clr = 1'b1;
    sb.delete();
    model_rdata = '0;
    @(negedge clk);
    checks++;
    if ({ack0, ack1, busy} !== 3'b0) begin
      failures++;
      $display("FAIL abort_idle: got ack=%b%b busy=%b want 000", ack0, ack1, busy);
    end
    din_val = 16'hCAFE;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 12'h010;
    push(1'b1, 1'b0, 12'h010, 16'h0000);
    wait_ack(n, p);
    req1 = 1'b0;
    checks++;
    if (n !== LAT + 2 || p !== 1'b1 || rdata !== 16'hCAFE) begin
      failures++;
      $display("FAIL abort_retry: got n=%0d port=%b rdata=%h want n=%0d port=1 rdata=CAFE",
               n, p, rdata, LAT + 2);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_contention();
    test_abort();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
